// File: rtl/bp_pkg.sv
// Shared field-width helpers, counter encodings and the saturating counter step
// used by the branch target buffer.
package bp_pkg;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_width(input int addr_width, input int entries);
        return addr_width - $clog2(entries) - 32'sd2;
    endfunction

    function automatic int ctr_weak_nt(input int cb);
        return (cb > 32'sd1) ? ((32'sd1 << (cb - 32'sd1)) - 32'sd1) : 32'sd0;
    endfunction

    function automatic int ctr_weak_t(input int cb);
        return 32'sd1 << (cb - 32'sd1);
    endfunction

    function automatic int ctr_max(input int cb);
        return (32'sd1 << cb) - 32'sd1;
    endfunction

    function automatic int sat_next(input int ctr, input int cb, input logic up);
        int r;
        if (up) begin
            r = (ctr >= ctr_max(cb)) ? ctr_max(cb) : ctr + 32'sd1;
        end else begin
            r = (ctr <= 32'sd0) ? 32'sd0 : ctr - 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_entry_array.sv
// BTB storage: valid/tag/target/counter per entry, combinational reads and one
// synchronous write port; flush clears valid bits and wins over the write.
module bp_entry_array
    import bp_pkg::*;
#(
    parameter int ENTRIES      = 64,
    parameter int COUNTER_BITS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int IDX_W        = 6,
    parameter int TAG_W        = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [IDX_W-1:0]        lk_idx,
    output logic                    lk_valid,
    output logic [TAG_W-1:0]        lk_tag,
    output logic [ADDR_WIDTH-1:0]   lk_target,
    output logic [COUNTER_BITS-1:0] lk_ctr,
    input  logic [IDX_W-1:0]        up_idx,
    output logic                    up_valid,
    output logic [TAG_W-1:0]        up_tag,
    output logic [ADDR_WIDTH-1:0]   up_target,
    output logic [COUNTER_BITS-1:0] up_ctr,
    input  logic                    wr_en,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [ADDR_WIDTH-1:0]   wr_target,
    input  logic [COUNTER_BITS-1:0] wr_ctr
);

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [TAG_W-1:0]        tag_d    [ENTRIES];
    logic [ADDR_WIDTH-1:0]   target_q [ENTRIES];
    logic [ADDR_WIDTH-1:0]   target_d [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_d    [ENTRIES];

    // Read ports: IF lookup and the update-side hit check.
    always_comb begin
        lk_valid  = valid_q[lk_idx];
        lk_tag    = tag_q[lk_idx];
        lk_target = target_q[lk_idx];
        lk_ctr    = ctr_q[lk_idx];
        up_valid  = valid_q[up_idx];
        up_tag    = tag_q[up_idx];
        up_target = target_q[up_idx];
        up_ctr    = ctr_q[up_idx];
    end

    // Next-state for the table; the write shares the update index.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = wr_tag;
            target_d[up_idx] = wr_target;
            ctr_d[up_idx]    = wr_ctr;
        end else begin
            valid_d = valid_q;
        end
    end

    // Table state registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= COUNTER_BITS'(ctr_weak_nt(COUNTER_BITS));
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters:
// zero-latency lookup for IF, one update per cycle from ID, plus statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES      = 64,
    parameter int COUNTER_BITS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_next_pc,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic                  update_uncond,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_mispredict,
    input  logic                  flush_all,
    output logic [STAT_WIDTH-1:0] stat_lookups,
    output logic [STAT_WIDTH-1:0] stat_updates,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(ADDR_WIDTH, ENTRIES);

    logic [IDX_W-1:0]        lk_idx_s, up_idx_s;
    logic [TAG_W-1:0]        lk_tag_s, up_tag_s, lk_tag_rd_s, up_tag_rd_s;
    logic                    lk_valid_s, up_valid_s, up_hit_s, up_go_s;
    logic [ADDR_WIDTH-1:0]   lk_target_s, up_target_s, wr_target_s;
    logic [COUNTER_BITS-1:0] lk_ctr_s, up_ctr_s, wr_ctr_s;
    logic                    wr_en_s;
    logic                    unused_pc_bits_s;
    logic [STAT_WIDTH-1:0]   stat_lookups_q, stat_lookups_d;
    logic [STAT_WIDTH-1:0]   stat_updates_q, stat_updates_d;
    logic [STAT_WIDTH-1:0]   stat_mispredicts_q, stat_mispredicts_d;

    assign lk_idx_s         = lookup_pc[IDX_W+1:2];
    assign lk_tag_s         = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
    assign up_idx_s         = update_pc[IDX_W+1:2];
    assign up_tag_s         = update_pc[ADDR_WIDTH-1:IDX_W+2];
    assign unused_pc_bits_s = ^{lookup_pc[1:0], update_pc[1:0]};

    bp_entry_array #(
        .ENTRIES     (ENTRIES),
        .COUNTER_BITS(COUNTER_BITS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .IDX_W       (IDX_W),
        .TAG_W       (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_all),
        .lk_idx   (lk_idx_s),
        .lk_valid (lk_valid_s),
        .lk_tag   (lk_tag_rd_s),
        .lk_target(lk_target_s),
        .lk_ctr   (lk_ctr_s),
        .up_idx   (up_idx_s),
        .up_valid (up_valid_s),
        .up_tag   (up_tag_rd_s),
        .up_target(up_target_s),
        .up_ctr   (up_ctr_s),
        .wr_en    (wr_en_s),
        .wr_tag   (up_tag_s),
        .wr_target(wr_target_s),
        .wr_ctr   (wr_ctr_s)
    );

    // Prediction from pre-edge table contents; no bypass of a same-cycle write.
    always_comb begin
        pred_hit     = lk_valid_s && (lk_tag_rd_s == lk_tag_s);
        pred_taken   = pred_hit && lk_ctr_s[COUNTER_BITS-1];
        if (pred_taken) begin
            pred_next_pc = lk_target_s;
        end else begin
            pred_next_pc = lookup_pc + ADDR_WIDTH'(32'd4);
        end
    end

    // Update policy: train on hit, allocate only on a taken miss.
    always_comb begin
        up_hit_s    = up_valid_s && (up_tag_rd_s == up_tag_s);
        up_go_s     = update_taken || update_uncond;
        wr_en_s     = 1'b0;
        wr_target_s = up_target_s;
        wr_ctr_s    = up_ctr_s;
        if (update_valid && up_hit_s) begin
            wr_en_s     = 1'b1;
            wr_target_s = up_go_s ? update_target : up_target_s;
            wr_ctr_s    = COUNTER_BITS'(sat_next(int'(up_ctr_s), COUNTER_BITS, up_go_s));
        end else if (update_valid && up_go_s) begin
            wr_en_s     = 1'b1;
            wr_target_s = update_target;
            wr_ctr_s    = COUNTER_BITS'(ctr_weak_t(COUNTER_BITS));
        end else begin
            wr_en_s = 1'b0;
        end
        if (update_uncond) begin
            wr_ctr_s = COUNTER_BITS'(ctr_max(COUNTER_BITS));
        end else begin
            wr_ctr_s = wr_ctr_s;
        end
    end

    // Statistics next-state; all counters wrap naturally.
    always_comb begin
        stat_lookups_d     = stat_lookups_q + STAT_WIDTH'(32'd1);
        stat_updates_d     = stat_updates_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (update_valid) begin
            stat_updates_d = stat_updates_q + STAT_WIDTH'(32'd1);
            if (update_mispredict) begin
                stat_mispredicts_d = stat_mispredicts_q + STAT_WIDTH'(32'd1);
            end else begin
                stat_mispredicts_d = stat_mispredicts_q;
            end
        end else begin
            stat_updates_d = stat_updates_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups_q     <= '0;
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_updates_q     <= stat_updates_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_updates     = stat_updates_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with default parameters.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic        update_valid, update_taken, update_uncond, update_mispredict, flush_all;
    logic [31:0] update_pc, update_target;
    logic [31:0] stat_lookups, stat_updates, stat_mispredicts;

    int checks   = 0;
    int failures = 0;
    int exp_lookups = 0;
    int exp_updates = 0;
    int exp_mispred = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_uncond    (update_uncond),
        .update_target    (update_target),
        .update_mispredict(update_mispredict),
        .flush_all        (flush_all),
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) exp_lookups++;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic un,
                             input logic [31:0] tgt, input logic mp);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_uncond     = un;
        update_target     = tgt;
        update_mispredict = mp;
        exp_updates++;
        if (mp) exp_mispred++;
        tick();
        update_valid      = 1'b0;
        update_taken      = 1'b0;
        update_uncond     = 1'b0;
        update_mispredict = 1'b0;
        flush_all         = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] nxt);
        lookup_pc = pc;
        #1;
        check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        check({tag, "_next"}, pred_next_pc, nxt);
    endtask

    initial begin
        reset = 1'b0;
        lookup_pc = 32'h0040_0000;
        update_valid = 1'b0; update_pc = 32'd0; update_taken = 1'b0; update_uncond = 1'b0;
        update_target = 32'd0; update_mispredict = 1'b0; flush_all = 1'b0;
        #22;
        reset = 1'b1;

        // 1. reset state
        look("reset", 32'h0040_0000, 1'b0, 1'b0, 32'h0040_0004);
        check("reset_lookups", stat_lookups, 32'd0);
        check("reset_updates", stat_updates, 32'd0);
        check("reset_mispred", stat_mispredicts, 32'd0);

        // 2. allocate with WEAK_T
        do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b0);
        look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);

        // 3. saturation and hysteresis: 2->3->3, then down
        do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b0);
        do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b0);
        look("ctr3", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
        do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b0);
        do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0999, 1'b0);
        look("sat_hi_ctr2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
        do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0999, 1'b0);
        look("ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0999, 1'b0);
        do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0999, 1'b0);
        do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0080, 1'b0);
        look("sat_lo_ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0080, 1'b0);
        look("retarget", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);

        // 4. aliasing at index 4, not-taken miss, unconditional allocation
        do_update(32'h0040_0110, 1'b1, 1'b0, 32'h0040_0200, 1'b0);
        look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        look("alias_new", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);
        do_update(32'h0040_0030, 1'b0, 1'b0, 32'h0040_0777, 1'b0);
        look("nt_miss", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
        do_update(32'h0040_0040, 1'b0, 1'b1, 32'h0040_0500, 1'b0);
        do_update(32'h0040_0040, 1'b0, 1'b0, 32'h0040_0500, 1'b0);
        look("uncond_max", 32'h0040_0040, 1'b1, 1'b1, 32'h0040_0500);

        // 5. same-cycle update and lookup: no bypass
        lookup_pc = 32'h0040_0020;
        update_valid = 1'b1; update_pc = 32'h0040_0020; update_taken = 1'b1;
        update_target = 32'h0040_0600;
        #1;
        check("nobypass_hit", {31'd0, pred_hit}, 32'd0);
        exp_updates++;
        tick();
        update_valid = 1'b0; update_taken = 1'b0;
        look("after_write", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0600);

        // 6. flush wins over simultaneous update, which is still counted
        flush_all = 1'b1;
        do_update(32'h0040_0050, 1'b1, 1'b0, 32'h0040_0700, 1'b0);
        look("flush_a", 32'h0040_0110, 1'b0, 1'b0, 32'h0040_0114);
        look("flush_b", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
        look("flush_c", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        check("flush_updates", stat_updates, exp_updates);
        do_update(32'h0040_0060, 1'b0, 1'b0, 32'h0040_0000, 1'b1);
        check("mispred_cnt", stat_mispredicts, exp_mispred);
        update_mispredict = 1'b1;
        tick();
        update_mispredict = 1'b0;
        check("mispred_novalid", stat_mispredicts, exp_mispred);
        check("updates_total", stat_updates, exp_updates);
        check("lookups_total", stat_lookups, exp_lookups);

        // asynchronous reset between edges
        do_update(32'h0040_0020, 1'b1, 1'b0, 32'h0040_0800, 1'b0);
        look("pre_reset", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0800);
        #1;
        reset = 1'b0;
        #1;
        check("async_hit", {31'd0, pred_hit}, 32'd0);
        check("async_next", pred_next_pc, 32'h0040_0024);
        check("async_lookups", stat_lookups, 32'd0);
        check("async_updates", stat_updates, 32'd0);
        check("async_mispred", stat_mispredicts, 32'd0);
        #1;
        reset = 1'b1;
        exp_lookups = 0;
        tick();
        look("post_reset", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        check("post_lookups", stat_lookups, exp_lookups);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
